// File: rtl/alu_cmd_stage.sv
// Registered command/result stage around a combinational ALU: IDLE -> EXEC -> HOLD.
// Optional accumulator-as-A operand enabled by defining ALU_CMD_ACC_EN.
module alu_cmd_stage #(
  parameter int BITS  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [BITS-1:0]  in_a,
  input  logic [BITS-1:0]  in_b,
  input  logic             in_flag,
  input  logic             in_use_acc,
  output logic [BITS-1:0]  alu_a,
  output logic [BITS-1:0]  alu_b,
  output logic             alu_flag_in,
  output logic [3:0]       alu_control,
  input  logic [BITS-1:0]  alu_result,
  input  logic             alu_flag_out,
  input  logic             alu_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BITS-1:0]  out_result,
  output logic             out_flag,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  typedef struct packed {
    logic [BITS-1:0] result;
    logic            flag;
    logic            carry;
    logic            zero;
    logic            illegal;
  } res_t;

  state_t          state, state_nxt;
  logic            cmd_fire, cap_en, out_fire;
  logic [BITS-1:0] a_sel;
  res_t            cap;

`ifdef ALU_CMD_ACC_EN
  logic [BITS-1:0] acc;
  assign a_sel = in_use_acc ? acc : in_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           acc <= '0;
    else if (out_fire) acc <= out_result;
  end
`else
  logic unused_use_acc;
  assign unused_use_acc = in_use_acc;
  assign a_sel          = in_a;
`endif

  // Ready depends only on state and reset, never on in_valid.
  assign in_ready = (state == IDLE) && !rst;

  always_comb begin
    state_nxt = state;
    cmd_fire  = 1'b0;
    cap_en    = 1'b0;
    out_fire  = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        cmd_fire  = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: begin
        cap_en    = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: if (out_valid && out_ready) begin
        out_fire  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Opcodes 0xD-0xF squash the ALU outputs to a zero result.
  always_comb begin
    cap = '0;
    if (alu_control >= 4'hD) begin
      cap.zero    = 1'b1;
      cap.illegal = 1'b1;
    end else begin
      cap.result = alu_result;
      cap.flag   = alu_flag_out;
      cap.carry  = alu_c;
      cap.zero   = (alu_result == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_flag_in <= 1'b0;
      alu_control <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_flag    <= 1'b0;
      out_carry   <= 1'b0;
      out_zero    <= 1'b0;
      out_illegal <= 1'b0;
      op_count    <= '0;
    end else begin
      state <= state_nxt;
      if (cmd_fire) begin
        alu_a       <= a_sel;
        alu_b       <= in_b;
        alu_flag_in <= in_flag;
        alu_control <= in_op;
      end
      if (cap_en) begin
        out_result  <= cap.result;
        out_flag    <= cap.flag;
        out_carry   <= cap.carry;
        out_zero    <= cap.zero;
        out_illegal <= cap.illegal;
        out_valid   <= 1'b1;
      end
      if (out_fire) begin
        out_valid <= 1'b0;
        op_count  <= op_count + 1'b1;
      end
    end
  end

endmodule

// File: doc/alu_cmd_stage.md
Name: alu_cmd_stage

Overview:
- Registered command and result stage wrapped around the combinational ALU (A, B, flag-in, 4-bit control in; result, flag and carry out).
- Accepts one ALU command per valid/ready handshake from the upstream sequencer and holds the operands stable on the ALU inputs.
- Captures the ALU result, flag, carry and a derived zero bit into output registers.
- Presents the captured result downstream with a valid/ready handshake.

Parameters:
- BITS, 8, datapath width of the operands and the result; must match the ALU instance parameter.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  command valid.
- in_ready  output  1  stage can accept a command.
- in_op  input  4  ALU opcode (0x0–0xC legal).
- in_a  input  BITS  operand A.
- in_b  input  BITS  operand B.
- in_flag  input  1  ALU flag-in (operand select / shift fill).
- in_use_acc  input  1  substitute last result for A; used only with ALU_CMD_ACC_EN.
- alu_a  output  BITS  registered operand to ALU A.
- alu_b  output  BITS  registered operand to ALU B.
- alu_flag_in  output  1  registered flag to ALU.
- alu_control  output  4  registered opcode to ALU.
- alu_result  input  BITS  ALU result.
- alu_flag_out  input  1  ALU flag output.
- alu_c  input  1  ALU carry.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_result  output  BITS  captured result.
- out_flag  output  1  captured ALU flag.
- out_carry  output  1  captured carry.
- out_zero  output  1  captured result equals 0.
- out_illegal  output  1  opcode was 0xD–0xF.
- op_count  output  CNT_W  completed output handshakes.

Behaviour:
- Reset (async, rst=1):
  - State IDLE.
  - All registered outputs 0: alu_*, out_*, op_count.
  - in_ready forced 0 while rst=1.
  - Accumulator register 0.
- FSM states: IDLE, EXEC, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at the clock edge: latch in_op, in_a, in_b and in_flag into the alu_* registers, then go to EXEC.
- EXEC:
  - Lasts exactly 1 cycle; in_ready=0.
  - The ALU evaluates combinationally from the stable alu_* registers.
  - At the end-of-cycle edge capture:
    - out_result = alu_result
    - out_flag = alu_flag_out
    - out_carry = alu_c
    - out_zero = (alu_result == 0)
  - Set out_valid=1 and go to HOLD.
- Illegal opcode:
  - If alu_control is 0xD–0xF, the capture step instead forces out_result=0, out_flag=0, out_carry=0, out_zero=1, out_illegal=1.
  - For legal opcodes out_illegal=0.
- HOLD:
  - in_ready=0.
  - All out_* stay stable while out_valid=1 and out_ready=0; no limit on stall length.
  - On out_valid & out_ready: out_valid←0, op_count←op_count+1 (wraps modulo 2^CNT_W), go to IDLE.
- Latency: command handshake edge to out_valid high is 2 clock edges. Peak throughput is one command per 3 cycles.
- alu_* registers keep their last values in HOLD and IDLE; they change only on a command handshake.
- out_ready is ignored outside HOLD. in_valid is ignored outside IDLE; upstream holds the command until in_ready.
- Reset mid-operation (EXEC or HOLD): the pending result is discarded, out_valid drops immediately (asynchronously), and op_count is cleared.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Optional Feature:
- Macro: ALU_CMD_ACC_EN.
- Defined:
  - A BITS-wide accumulator register loads out_result on every output handshake, including illegal ops, which load 0.
  - If in_use_acc=1 at command handshake, alu_a latches the accumulator instead of in_a.
  - The accumulator resets to 0.
- Undefined:
  - in_use_acc is ignored and alu_a always latches in_a.
  - No accumulator register is built.

Test Plan:
- AND: op 0x0, A=F0, B=0F, out_ready=1 → out_valid 2 edges after handshake; out_result=00, out_zero=1, op_count=1.
- Add overflow: op 0x3, A=FF, B=01 → out_result=00, out_carry=1, out_zero=1. Then op 0x3, A=0A, B=05 → 0F, out_carry=0, out_zero=0.
- Backpressure: op 0x4, A=0A, B=05; out_ready=0 for 6 cycles → out_valid=1 with out_result=05 stable throughout, in_ready=0; on out_ready=1, one handshake occurs, op_count increments once, in_ready returns 1 the next cycle.
- Illegal: op 0xE, A=12, B=34 → out_result=00, out_illegal=1, out_zero=1; the next legal op 0x7, F0^0F → FF with out_illegal=0.
- Reset mid-HOLD: issue op 0x1, keep out_ready=0, assert rst in HOLD → out_valid=0 and op_count=0 immediately. After release, in_ready=1 and a new command completes normally.
- With ALU_CMD_ACC_EN: op 0x3, A=0A, B=05 → 0F. Then op 0x3, in_use_acc=1, in_a=99, B=01 → alu_a=0F and out_result=10.
